// File: rtl/dds_dsm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dds_dsm_pkg : shared widths, sine table constants and the LUT generator     |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
package dds_dsm_pkg;

   localparam int DDS_PHASE_W  = 32;
   localparam int DDS_LUT_AW   = 10;
   localparam int DDS_SAMPLE_W = 16;

   localparam int                       LUT_DEPTH = 1 << DDS_LUT_AW;
   localparam logic [DDS_SAMPLE_W-1:0]  MID       = 16'h8000;
   localparam int                       AMP       = 32767;
   localparam real                      c_pi      = 3.14159265358979323846;

   typedef enum logic {
      SRC_DDS = 1'b0,
      SRC_EXT = 1'b1
   } dac_src_e;

   // Quarter-wave symmetry keeps the Taylor argument within [0, pi/2], where
   // twelve terms are far below one LSB of error.
   function automatic logic [DDS_SAMPLE_W-1:0] sine_word(input int k, input int depth);
      int  quad;
      int  idx;
      int  mag;
      real x;
      real term;
      real sum;
      quad = (k / (depth / 4)) % 4;
      idx  = k % (depth / 4);
      if (quad == 1 || quad == 3) begin
         idx = depth / 4 - idx;
      end
      x    = 2.0 * c_pi * $itor(idx) / $itor(depth);
      term = x;
      sum  = x;
      for (int n = 1; n <= 12; n++) begin
         term = -term * x * x / $itor((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      mag = $rtoi($itor(AMP) * sum + 0.5);
      if (quad >= 2) begin
         mag = -mag;
      end
      mag = int'(MID) + mag;
      return mag[DDS_SAMPLE_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/dds_dsm_dac_sd_modulator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sd_modulator : first-order delta-sigma 1-bit modulator, offset-binary input |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
module sd_modulator
   import dds_dsm_pkg::*;
#(
   parameter int WIDTH = DDS_SAMPLE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] sample,
   output logic             bitstream
);

   localparam logic [WIDTH-1:0] c_mid = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] r_din;
   logic [WIDTH-1:0] r_dacc;
   logic             r_bit;
   logic [WIDTH:0]   w_sum;

   assign w_sum     = {1'b0, r_dacc} + {1'b0, r_din};
   assign bitstream = r_bit;

   // The carry out of the accumulator is the output pulse; its long-run
   // density is exactly din / 2^WIDTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din  <= c_mid;
         r_dacc <= '0;
         r_bit  <= 1'b0;
      end else begin
         r_din <= sample;
         if (en) begin
            r_dacc <= w_sum[WIDTH-1:0];
            r_bit  <= w_sum[WIDTH];
         end else begin
            r_bit  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dds_dsm_dac.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dds_dsm_dac : DDS sine source feeding a 1-bit delta-sigma DAC modulator     |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module dds_dsm_dac
   import dds_dsm_pkg::*;
#(
   parameter int PHASE_W  = DDS_PHASE_W,
   parameter int LUT_AW   = DDS_LUT_AW,
   parameter int SAMPLE_W = DDS_SAMPLE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PHASE_W-1:0]  freq,
   input  logic [PHASE_W-1:0]  phase,
   output logic [SAMPLE_W-1:0] signal1,
   input  logic                en,
   input  logic                src_ext,
   input  logic [SAMPLE_W-1:0] signal,
   output logic                bitstream
);

   localparam int c_depth = 1 << LUT_AW;

   logic [PHASE_W-1:0]  r_acc;
   logic [SAMPLE_W-1:0] r_signal1;
   logic [LUT_AW-1:0]   w_addr;
   logic [SAMPLE_W-1:0] w_dac_sample;
   logic [SAMPLE_W-1:0] w_lut [c_depth];

   for (genvar k = 0; k < c_depth; k++) begin : g_lut
      localparam logic [DDS_SAMPLE_W-1:0] c_word = sine_word(k, c_depth);
      assign w_lut[k] = SAMPLE_W'(c_word);
   end

   // Offset is applied to the pre-update accumulator; only the top bits address the ROM.
   assign w_addr  = LUT_AW'((r_acc + phase) >> (PHASE_W - LUT_AW));
   assign signal1 = r_signal1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_signal1 <= SAMPLE_W'(MID);
      end else begin
         r_acc     <= r_acc + freq;
         r_signal1 <= w_lut[w_addr];
      end
   end

   assign w_dac_sample = (dac_src_e'(src_ext) == SRC_EXT) ? signal : r_signal1;

   sd_modulator #(
      .WIDTH     (SAMPLE_W)
   ) u_sd_modulator (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sample    (w_dac_sample),
      .bitstream (bitstream)
   );

endmodule
`default_nettype wire

// File: tb/tb_dds_dsm_dac.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dds_dsm_dac : randomized bench against an arithmetic DDS/DAC model       |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module tb_dds_dsm_dac;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic [31:0] freq    = '0;
   logic [31:0] phase   = '0;
   logic [15:0] signal1;
   logic        en      = 1'b0;
   logic        src_ext = 1'b0;
   logic [15:0] signal  = '0;
   logic        bitstream;

   int n_checks = 0;
   int n_fail   = 0;
   int ones     = 0;

   // Model state: phase, sine word, DAC input and the running sum of all
   // samples fed to the modulator (its carries are the output pulses).
   bit [31:0] m_acc;
   int        m_sig1;
   int        m_din;
   longint    m_sum;
   bit        m_bit;

   always #5 clk = ~clk;

   dds_dsm_dac u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .freq      (freq),
      .phase     (phase),
      .signal1   (signal1),
      .en        (en),
      .src_ext   (src_ext),
      .signal    (signal),
      .bitstream (bitstream)
   );

   function automatic int ref_sine(input int k);
      real a;
      a = 2.0 * 3.14159265358979323846 * $itor(k) / 1024.0;
      return 32768 + int'(32767.0 * $sin(a));
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc  = '0;
      m_sig1 = 32'h8000;
      m_din  = 32'h8000;
      m_sum  = 0;
      m_bit  = 1'b0;
   endtask

   task automatic step();
      bit [31:0] s;
      int        nsig1;
      int        ndin;
      longint    nsum;
      bit        nbit;
      s     = m_acc + phase;
      nsig1 = ref_sine(int'(s[31:22]));
      ndin  = src_ext ? int'(signal) : m_sig1;
      if (en) begin
         nsum = m_sum + longint'(m_din);
         nbit = (nsum / 65536) != (m_sum / 65536);
      end else begin
         nsum = m_sum;
         nbit = 1'b0;
      end
      @(posedge clk);
      #1;
      m_acc  = m_acc + freq;
      m_sig1 = nsig1;
      m_din  = ndin;
      m_sum  = nsum;
      m_bit  = nbit;
      check_val("signal1", {16'h0, signal1}, m_sig1);
      check_val("bitstream", {31'h0, bitstream}, {31'h0, m_bit});
      if (bitstream === 1'b1) ones++;
   endtask

   // Asynchronous assert away from the clock edge, release on a falling edge.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_val("rst_signal1", {16'h0, signal1}, 32'h8000);
      check_val("rst_bitstream", {31'h0, bitstream}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int        vmax;
      int        vmin;
      int        zeros;
      logic      prev;
      bit [31:0] ph;

      // Reset held with arbitrary inputs, then first word after release.
      model_reset();
      freq    = $urandom;
      phase   = $urandom;
      en      = 1'b1;
      src_ext = 1'b1;
      signal  = 16'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check_val("hold_rst_signal1", {16'h0, signal1}, 32'h8000);
      check_val("hold_rst_bitstream", {31'h0, bitstream}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ph    = phase;
      step();
      check_val("first_signal1", {16'h0, signal1}, ref_sine(int'(ph[31:22])));
      repeat (20) step();

      // Static phase offsets with a frozen accumulator.
      freq = '0;
      do_reset();
      phase = 32'h4000_0000;
      repeat (4) step();
      check_val("phase_90", {16'h0, signal1}, 32'hFFFF);
      phase = 32'hC000_0000;
      repeat (2) step();
      check_val("phase_270", {16'h0, signal1}, 32'h0001);
      phase = 32'h0;
      repeat (2) step();
      check_val("phase_0", {16'h0, signal1}, 32'h8000);

      // Tone through the DAC with periodic enable gaps.
      do_reset();
      freq    = 32'd157482;
      src_ext = 1'b0;
      en      = 1'b1;
      vmax    = 0;
      vmin    = 65536;
      for (int i = 0; i < 21000; i++) begin
         en = !((i % 500) >= 100 && (i % 500) < 110);
         step();
         if (int'(signal1) > vmax) vmax = int'(signal1);
         if (int'(signal1) < vmin) vmin = int'(signal1);
      end
      check_val("tone_peak_hi", vmax, 32'hFFFF);
      check_val("tone_peak_lo", vmin, 32'h0001);

      // DAC density with an external source.
      do_reset();
      freq    = $urandom;
      en      = 1'b1;
      src_ext = 1'b1;
      signal  = 16'h4000;
      repeat (2) step();
      ones = 0;
      repeat (400) step();
      check_val("density_quarter", ones, 32'd100);

      signal = 16'h0000;
      repeat (2) step();
      ones = 0;
      repeat (200) step();
      check_val("density_zero", ones, 32'd0);

      signal = 16'h8000;
      repeat (2) step();
      ones = 0;
      prev = bitstream;
      for (int i = 0; i < 200; i++) begin
         step();
         if (i < 16) check_val("mid_alternate", {31'h0, bitstream}, {31'h0, ~prev});
         prev = bitstream;
      end
      check_val("density_half", ones, 32'd100);

      signal = 16'hFFFF;
      repeat (2) step();
      ones = 0;
      repeat (3000) step();
      zeros = 3000 - ones;
      check_val("full_scale_zeros", {31'h0, zeros <= 1}, 32'h1);

      // Enable pause: output forced low, sequence resumes from the frozen state.
      signal = 16'h5A5A;
      repeat (30) step();
      en   = 1'b0;
      ones = 0;
      repeat (10) step();
      check_val("paused_ones", ones, 32'd0);
      en = 1'b1;
      repeat (30) step();

      // Random source switching, samples, tuning and enable.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) src_ext = ~src_ext;
         if ($urandom_range(0, 31) == 0) en = ~en;
         if ($urandom_range(0, 63) == 0) freq = $urandom;
         if ($urandom_range(0, 63) == 0) phase = $urandom;
         signal = 16'($urandom);
         step();
      end

      // Reset in the middle of activity, then restart.
      en = 1'b1;
      do_reset();
      repeat (50) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
